// File: rtl/sipo_lsb_rx_pkg.sv
// Shared types and helpers for the LSB-first serial-in/parallel-out receiver.
package sipo_lsb_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        HOLD  = 2'd3
    } sipo_state_e;

    // Bit-counter width able to represent 0..dw inclusive.
    function automatic int unsigned cnt_w(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/sipo_lsb_rx_bit_counter.sv
// Frame bit counter: synchronous clear / load-1, enabled saturating increment,
// terminal-count flag at TC.
module bit_counter #(
    parameter int unsigned W  = 3,
    parameter int unsigned TC = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load1,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_tc_c
);

    logic [W-1:0] r_cnt;
    logic         w_tc;

    assign w_tc   = (r_cnt == W'(TC));
    assign o_cnt  = r_cnt;
    assign o_tc_c = w_tc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= W'(1);
        end else if (i_inc && !w_tc) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/sipo_lsb_rx.sv
// LSB-first serial receiver with valid/ready word output.
// Optional even-parity bit per frame when SIPO_LSB_RX_PARITY_EN is defined.
module sipo_lsb_rx #(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          start,
    input  logic          sin,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          overrun,
    output logic          parity_err
);
    import sipo_lsb_rx_pkg::*;

    localparam int unsigned CW = cnt_w(DW);

    sipo_state_e   r_state;
    logic [DW-1:0] r_shreg;
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_overrun;
    logic          r_perr;

    logic [CW-1:0] w_cnt;
    logic          w_tc;
    logic          w_last;
    logic          w_clr;
    logic          w_load1;
    logic          w_inc;
    logic [DW-1:0] w_shift;

    // New bit enters at the MSB; after DW shifts bit 0 sits at the LSB.
    assign w_shift = DW'({sin, r_shreg} >> 1);
    assign w_last  = (w_cnt == CW'(DW - 1));

    bit_counter #(
        .W  (CW),
        .TC (DW)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_load1 (w_load1),
        .i_inc   (w_inc),
        .o_cnt   (w_cnt),
        .o_tc_c  (w_tc)
    );

    // Counter control follows the same start/enable decisions as the FSM.
    always_comb begin
        w_clr   = 1'b0;
        w_load1 = 1'b0;
        w_inc   = 1'b0;
        case (r_state)
            IDLE:  w_load1 = enb && start;
            SHIFT: begin
                if (enb) begin
                    if (start) w_load1 = 1'b1;
                    else       w_inc   = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (enb && start) w_load1 = 1'b1;
                    else              w_clr   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enb && start) begin
                        r_shreg <= w_shift;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (enb) begin
                        r_shreg <= w_shift;
                        // A start here restarts the frame, so only a plain bit can complete it.
                        if (!start && w_last) begin
`ifdef SIPO_LSB_RX_PARITY_EN
                            r_state <= PAR;
`else
                            r_data  <= w_shift;
                            r_valid <= 1'b1;
                            r_state <= HOLD;
`endif
                        end
                    end
                end
`ifdef SIPO_LSB_RX_PARITY_EN
                PAR: begin
                    if (enb) begin
                        r_data  <= r_shreg;
                        r_perr  <= ^{sin, r_shreg};
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
`endif
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        r_perr  <= 1'b0;
                        if (enb && start) begin
                            r_shreg <= w_shift;
                            r_state <= SHIFT;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (enb && start) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Mid-frame the counter holds 1..DW-1, so it can never sit at terminal count.
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
        (r_state == SHIFT) |-> !w_tc);

    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign overrun    = r_overrun;
    assign parity_err = r_perr;

endmodule
